// File: rtl/procyon_ieu_mdu_ex.sv
// rtl/procyon_ieu_mdu_ex.sv - iterative RV32M/RV64M multiply/divide execute stage
// Optional feature macro: PCYN_MDU_EARLY_OUT_EN (MUL* leaves CALC once the remaining multiplier is zero)
// Ports: clk, n_rst (async, active-low), i_flush (discard in-flight op),
//        i_valid/o_ready op handshake, i_mdu_func/i_src_a/i_src_b/i_tag op fields,
//        o_valid (one-cycle pulse)/o_data/o_tag result.
module procyon_ieu_mdu_ex #(
  parameter int OPTN_DATA_WIDTH         = 32,
  parameter int OPTN_ROB_IDX_WIDTH      = 5,
  parameter int OPTN_MDU_BITS_PER_CYCLE = 1
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [2:0]                    i_mdu_func,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_src_a,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_src_b,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_tag,
  output logic                          o_valid,
  output logic [OPTN_DATA_WIDTH-1:0]    o_data,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_tag
);

  localparam int W  = OPTN_DATA_WIDTH;
  localparam int B  = OPTN_MDU_BITS_PER_CYCLE;
  localparam int N  = W / B;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef PCYN_MDU_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                        state;
  logic [2:0]                    func;
  logic [OPTN_ROB_IDX_WIDTH-1:0] tag;
  logic                          neg;    // final result must be negated
  logic [CW-1:0]                 cnt;
  logic [2*W-1:0]                prod;   // product accumulator
  logic [2*W-1:0]                mcand;  // multiplicand, pre-shifted to current weight
  logic [W-1:0]                  mq;     // multiplier (MUL*) or dividend->quotient (DIV*)
  logic [W-1:0]                  dvs;    // divisor magnitude
  logic [W:0]                    rem;    // partial remainder, one guard bit

  assign o_ready = (state == IDLE);

  // Operand conditioning at accept time
  logic           signed_a, signed_b, a_neg, b_neg, b_zero, div_ovf, special;
  logic [W-1:0]   abs_a, abs_b;
  always_comb begin
    signed_a = (i_mdu_func == 3'd0) || (i_mdu_func == 3'd1) || (i_mdu_func == 3'd2) ||
               (i_mdu_func == 3'd4) || (i_mdu_func == 3'd6);
    signed_b = (i_mdu_func == 3'd0) || (i_mdu_func == 3'd1) ||
               (i_mdu_func == 3'd4) || (i_mdu_func == 3'd6);
    a_neg    = signed_a & i_src_a[W-1];
    b_neg    = signed_b & i_src_b[W-1];
    abs_a    = a_neg ? -i_src_a : i_src_a;
    abs_b    = b_neg ? -i_src_b : i_src_b;
    b_zero   = (i_src_b == '0);
    div_ovf  = ((i_mdu_func == 3'd4) || (i_mdu_func == 3'd6)) &&
               (i_src_a == {1'b1, {(W-1){1'b0}}}) && (i_src_b == '1);
    special  = i_mdu_func[2] & (b_zero | div_ovf);
  end

  // One iteration: B shift-add steps or B restoring-division steps
  logic [2*W-1:0] prod_nxt;
  logic [W:0]     rem_nxt;
  logic [W-1:0]   quo_nxt;
  always_comb begin
    prod_nxt = prod;
    for (int i = 0; i < B; i++) begin
      if (mq[i]) prod_nxt = prod_nxt + (mcand << i);
    end
    rem_nxt = rem;
    quo_nxt = mq;
    for (int i = 0; i < B; i++) begin
      rem_nxt = {rem_nxt[W-1:0], quo_nxt[W-1]};
      quo_nxt = {quo_nxt[W-2:0], 1'b0};
      if (rem_nxt >= {1'b0, dvs}) begin
        rem_nxt    = rem_nxt - {1'b0, dvs};
        quo_nxt[0] = 1'b1;
      end
    end
  end

  // The multiplicand is kept at its true weight, so an early exit needs no re-alignment
  logic mul_last;
  assign mul_last = (cnt == LAST) || (EARLY_OUT && ((mq >> B) == '0));

  // Sign fix-up and field select
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, result;
  always_comb begin
    prod_fix = neg ? -prod : prod;
    quo_fix  = neg ? -mq : mq;
    rem_fix  = neg ? -rem[W-1:0] : rem[W-1:0];
    case (func)
      3'd0:             result = prod_fix[W-1:0];
      3'd1, 3'd2, 3'd3: result = prod_fix[2*W-1:W];
      3'd4, 3'd5:       result = quo_fix;
      default:          result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      func    <= '0;
      tag     <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
      mq      <= '0;
      dvs     <= '0;
      rem     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_tag   <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_valid) begin
              func <= i_mdu_func;
              tag  <= i_tag;
              cnt  <= '0;
              if (special) begin
                // Load regs so the normal DONE select yields the architectural result
                state <= DONE;
                neg   <= 1'b0;
                mq    <= b_zero ? '1 : {1'b1, {(W-1){1'b0}}};
                rem   <= b_zero ? {1'b0, i_src_a} : '0;
              end else if (i_mdu_func[2]) begin
                state <= CALC;
                neg   <= (i_mdu_func == 3'd4) ? (a_neg ^ b_neg) : a_neg;
                rem   <= '0;
                mq    <= abs_a;
                dvs   <= abs_b;
              end else begin
                state <= CALC;
                neg   <= a_neg ^ b_neg;
                prod  <= '0;
                mcand <= {{W{1'b0}}, abs_a};
                mq    <= abs_b;
              end
            end
          end
          CALC: begin
            cnt <= cnt + CW'(1);
            if (func[2]) begin
              rem <= rem_nxt;
              mq  <= quo_nxt;
              if (cnt == LAST) state <= DONE;
            end else begin
              prod  <= prod_nxt;
              mcand <= mcand << B;
              mq    <= mq >> B;
              if (mul_last) state <= DONE;
            end
          end
          DONE: begin
            state   <= IDLE;
            o_valid <= 1'b1;
            o_data  <= result;
            o_tag   <= tag;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_procyon_ieu_mdu_ex.sv
// tb/tb_procyon_ieu_mdu_ex.sv - directed self-checking bench for procyon_ieu_mdu_ex (B=1 and B=4 instances)
module tb_procyon_ieu_mdu_ex;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic [2:0]  i_mdu_func = '0;
  logic [31:0] i_src_a = '0;
  logic [31:0] i_src_b = '0;
  logic [4:0]  i_tag = '0;

  logic        o_ready, o_valid;
  logic [31:0] o_data;
  logic [4:0]  o_tag;
  logic        o_ready4, o_valid4;
  logic [31:0] o_data4;
  logic [4:0]  o_tag4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  procyon_ieu_mdu_ex #(.OPTN_DATA_WIDTH(32), .OPTN_ROB_IDX_WIDTH(5), .OPTN_MDU_BITS_PER_CYCLE(1)) dut (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_mdu_func(i_mdu_func), .i_src_a(i_src_a), .i_src_b(i_src_b), .i_tag(i_tag),
    .o_valid(o_valid), .o_data(o_data), .o_tag(o_tag)
  );

  procyon_ieu_mdu_ex #(.OPTN_DATA_WIDTH(32), .OPTN_ROB_IDX_WIDTH(5), .OPTN_MDU_BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready4),
    .i_mdu_func(i_mdu_func), .i_src_a(i_src_a), .i_src_b(i_src_b), .i_tag(i_tag),
    .o_valid(o_valid4), .o_data(o_data4), .o_tag(o_tag4)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Cycle (accept cycle = 0) in which o_valid is expected to be high
  function automatic int exp_lat(input int bpc, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          n;
    int          it;
    logic [31:0] m;
    n  = 32 / bpc;
    it = 0;
    m  = '0;
    if (f[2] && ((b == 32'd0) || (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))))
      return 2;
`ifdef PCYN_MDU_EARLY_OUT_EN
    if (!f[2]) begin
      m = (((f == 3'd0) || (f == 3'd1)) && b[31]) ? -b : b;
      do begin
        it++;
        m = m >> bpc;
      end while ((m != 32'd0) && (it < n));
      return it + 2;
    end
`endif
    return n + 2 + (it * 0) + int'(m * 0);
  endfunction

  // Called at a negedge with both DUTs idle; op is accepted on the next posedge
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] exp);
    int          lat1, lat4, p1, p4;
    logic [31:0] d1, d4;
    logic [4:0]  t1, t4;
    logic        r1, r4;
    lat1 = 0; lat4 = 0; p1 = 0; p4 = 0;
    d1 = '0; d4 = '0; t1 = '0; t4 = '0; r1 = 1'b1; r4 = 1'b1;
    i_mdu_func = f; i_src_a = a; i_src_b = b; i_tag = t; i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) begin r1 = o_ready; r4 = o_ready4; end
      if (o_valid) begin
        p1++;
        if (lat1 == 0) begin lat1 = c; d1 = o_data; t1 = o_tag; end
      end
      if (o_valid4) begin
        p4++;
        if (lat4 == 0) begin lat4 = c; d4 = o_data4; t4 = o_tag4; end
      end
      @(negedge clk);
    end
    check({name, ".data"},   64'(d1), 64'(exp));
    check({name, ".tag"},    64'(t1), 64'(t));
    check({name, ".lat"},    64'(lat1), 64'(exp_lat(1, f, a, b)));
    check({name, ".pulses"}, 64'(p1), 64'd1);
    check({name, ".busy"},   64'(r1), 64'd0);
    check({name, ".hold"},   64'(o_data), 64'(exp));
    check({name, ".data4"},  64'(d4), 64'(exp));
    check({name, ".tag4"},   64'(t4), 64'(t));
    check({name, ".lat4"},   64'(lat4), 64'(exp_lat(4, f, a, b)));
    check({name, ".pulses4"}, 64'(p4), 64'd1);
    check({name, ".busy4"},  64'(r4), 64'd0);
  endtask

  initial begin
    int seen;
    seen = 0;
    repeat (3) @(negedge clk);
    check("rst.ready", 64'(o_ready), 64'd1);
    check("rst.valid", 64'(o_valid), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);
    check("reset.ready", 64'(o_ready), 64'd1);
    check("reset.valid", 64'(o_valid), 64'd0);
    check("reset.data",  64'(o_data),  64'd0);
    check("reset.tag",   64'(o_tag),   64'd0);

    run_op("mul_7x6",       3'd0, 32'd7,         32'd6,         5'd3,  32'd42);
    run_op("mulh_m1xm1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000);
    run_op("mulhu_ff",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE);
    run_op("mulhsu_m1x2",   3'd2, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF);
    run_op("mul_m3x5",      3'd0, 32'hFFFF_FFFD, 32'd5,         5'd7,  32'hFFFF_FFF1);
    run_op("mul_x1",        3'd0, 32'h1234_5678, 32'd1,         5'd8,  32'h1234_5678);
    run_op("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD);
    run_op("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF);
    run_op("div_7_m2",      3'd4, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD);
    run_op("rem_7_m2",      3'd6, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1);
    run_op("divu_7_2",      3'd5, 32'd7,         32'd2,         5'd13, 32'd3);
    run_op("remu_100_7",    3'd7, 32'd100,       32'd7,         5'd14, 32'd2);
    run_op("divu_5_0",      3'd5, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF);
    run_op("remu_5_0",      3'd7, 32'd5,         32'd0,         5'd16, 32'd5);
    run_op("div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000);
    run_op("rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0);

    // Flush mid-calculation: B=1 instance must never report the flushed op
    i_mdu_func = 3'd0; i_src_a = 32'd3; i_src_b = 32'd5; i_tag = 5'd9; i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (o_valid) seen++;
      if (c == 10) i_flush = 1'b1;
      @(negedge clk);
    end
    i_flush = 1'b0;
    if (o_valid) seen++;
    check("flush.ready11", 64'(o_ready), 64'd1);
    check("flush.no_valid", 64'(seen), 64'd0);
    run_op("post_flush", 3'd0, 32'h10, 32'h10, 5'd17, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
